// File: rtl/qmult_pkg.sv
// Shared types and bit-index helpers for the shared Q-format multiplier arbiter.
package qmult_pkg;

    localparam int unsigned N_DEF = 32;
    localparam int unsigned Q_DEF = 15;
    // Tag ID is sized for the largest supported requester count (8).
    localparam int unsigned ID_W  = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            sign;
    } tag_t;

    // Result magnitude slice of the 2N-bit product.
    function automatic int unsigned slice_hi(input int unsigned n, input int unsigned q);
        return n - 2 + q;
    endfunction

    function automatic int unsigned slice_lo(input int unsigned q);
        return q;
    endfunction

    // Product bits above the result slice; any set bit means overflow.
    function automatic int unsigned ovr_hi(input int unsigned n);
        return 2 * n - 2;
    endfunction

    function automatic int unsigned ovr_lo(input int unsigned n, input int unsigned q);
        return n - 1 + q;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first valid requester at or after ptr, wrapping.
module rr_pick #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    // Scan ptr, ptr+1, ... modulo NREQ and take the first valid one.
    always_comb begin
        int unsigned c;
        logic [IW-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            c = 32'(ptr_i) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            cand = IW'(c);
            if (!any_o && valid_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qmult_share_arb.sv
// Time-shares one pipelined sign-magnitude Q multiplier among NREQ requesters.
module qmult_share_arb
    import qmult_pkg::*;
#(
    parameter  int unsigned N    = N_DEF,
    parameter  int unsigned Q    = Q_DEF,
    parameter  int unsigned NREQ = 4,
    parameter  int unsigned LAT  = 3,
    localparam int unsigned IW   = $clog2(NREQ),
    localparam int unsigned CW   = $clog2(LAT + 2) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    input  logic [2*N-1:0]    mul_p,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_data,
    output logic              rsp_ovr,
    output logic [CW-1:0]     inflight
);

    localparam int unsigned SliceHi = slice_hi(N, Q);
    localparam int unsigned SliceLo = slice_lo(Q);
    localparam int unsigned OvrHi   = ovr_hi(N);
    localparam int unsigned OvrLo   = ovr_lo(N, Q);

    logic [IW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    tag_t            tag_q [LAT+1];
    tag_t            tag_d [LAT+1];
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [N-1:0]    rsp_data_q, rsp_data_d;
    logic            rsp_ovr_q, rsp_ovr_d;
    logic [CW-1:0]   inflight_q, inflight_d;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            issue;
    logic [N-1:0]    a_sel, b_sel;
    tag_t            aligned;

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .valid_i(req_valid),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    // Grant is suppressed during reset; a grant is always a handshake.
    always_comb begin
        req_ready = rst ? '0 : gnt;
        issue     = gnt_any & ~rst;
        a_sel     = req_a[32'(gnt_idx) * N +: N];
        b_sel     = req_b[32'(gnt_idx) * N +: N];
    end

    // Issue register, RR pointer advance and tag shift pipeline.
    always_comb begin
        ptr_d    = ptr_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        tag_d[0] = '0;
        if (issue) begin
            ptr_d    = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            mul_a_d  = {1'b0, a_sel[N-2:0]};
            mul_b_d  = {1'b0, b_sel[N-2:0]};
            tag_d[0] = '{valid: 1'b1, id: ID_W'(gnt_idx), sign: a_sel[N-1] ^ b_sel[N-1]};
        end
        for (int unsigned k = 1; k <= LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // Response stage: sign, Q-slice and overflow from the tag aligned with mul_p.
    always_comb begin
        aligned     = tag_q[LAT];
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_ovr_d   = rsp_ovr_q;
        if (aligned.valid) begin
            rsp_valid_d = NREQ'(1) << aligned.id;
            rsp_data_d  = {aligned.sign, mul_p[SliceHi:SliceLo]};
            rsp_ovr_d   = |mul_p[OvrHi:OvrLo];
        end
    end

    // Outstanding-operation count; a response retires when its strobe is visible.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({issue, |rsp_valid_q})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_ovr_q   <= 1'b0;
            inflight_q  <= '0;
            for (int unsigned k = 0; k <= LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovr_q   <= rsp_ovr_d;
            inflight_q  <= inflight_d;
            for (int unsigned k = 0; k <= LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ovr   = rsp_ovr_q;
    assign inflight  = inflight_q;

    // Product MSB is always zero and the fraction below the slice is truncated.
    logic unused_mul_p;
    assign unused_mul_p = ^{mul_p[2*N-1], mul_p[SliceLo-1:0]};

endmodule

// File: tb/tb_qmult_share_arb.sv
// Scoreboard bench: stimulus pushes expected responses, a monitor pops and compares.
module tb_qmult_share_arb;

    localparam int N    = 32;
    localparam int Q    = 15;
    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int CW   = $clog2(LAT + 2) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic [N-1:0]      mul_a, mul_b;
    logic [2*N-1:0]    mul_p;
    logic [NREQ-1:0]   rsp_valid;
    logic [N-1:0]      rsp_data;
    logic              rsp_ovr;
    logic [CW-1:0]     inflight;

    qmult_share_arb #(
        .N(N), .Q(Q), .NREQ(NREQ), .LAT(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_ovr  (rsp_ovr),
        .inflight (inflight)
    );

    always #5 clk = ~clk;

    // Multiplier model: product valid LAT cycles after mul_a/mul_b, never reset.
    logic [2*N-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mul_p = pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        ovr;
    } exp_t;

    exp_t exp_q [$];
    int   rsp_cyc [$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   rsp_seen = 0;
    int   last_rsp_cyc = 0;
    int   issue_cyc = 0;
    int   peak = 0;

    logic [31:0] ra [4];
    logic [31:0] rb [4];
    logic [31:0] ed [4];
    logic        eo [4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every response strobe is matched against the oldest expectation.
    always @(negedge clk) begin
        if (int'(inflight) > peak) peak = int'(inflight);
        if (rsp_valid != '0) begin
            rsp_seen++;
            last_rsp_cyc = cyc;
            rsp_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.id));
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_ovr", 64'(rsp_ovr), 64'(e.ovr));
            end
        end
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] d, input logic o);
        ra[i] = a;
        rb[i] = b;
        ed[i] = d;
        eo[i] = o;
    endtask

    // One cycle of stimulus; called just after a rising edge.
    task automatic step(input logic [3:0] v, input logic [3:0] eg);
        req_valid = v;
        req_a     = {ra[3], ra[2], ra[1], ra[0]};
        req_b     = {rb[3], rb[2], rb[1], rb[0]};
        @(negedge clk);
        check("grant", 64'(req_ready), 64'(eg));
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                exp_q.push_back('{id: i, data: ed[i], ovr: eo[i]});
                issue_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'b0000, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen0;
        for (int i = 0; i < 4; i++) set_op(i, 32'h0, 32'h0, 32'h0, 1'b0);
        rst       = 1'b1;
        req_valid = 4'hf;
        req_a     = '0;
        req_b     = '0;
        @(negedge clk);
        check("ready_in_reset", 64'(req_ready), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 4'h0;
        @(negedge clk);
        check("rst_mul_a", 64'(mul_a), 64'(0));
        check("rst_mul_b", 64'(mul_b), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_rsp_ovr", 64'(rsp_ovr), 64'(0));
        check("rst_inflight", 64'(inflight), 64'(0));
        @(posedge clk);
        #1;

        // Fairness: b = 1.0 so each result equals its multiplicand.
        set_op(0, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 1'b0);
        set_op(1, 32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 1'b0);
        set_op(2, 32'h0001_8000, 32'h0000_8000, 32'h0001_8000, 1'b0);
        set_op(3, 32'h0002_0000, 32'h0000_8000, 32'h0002_0000, 1'b0);
        rsp_cyc.delete();
        peak = 0;
        for (int r = 0; r < 2; r++) begin
            step(4'hf, 4'b0001);
            step(4'hf, 4'b0010);
            step(4'hf, 4'b0100);
            step(4'hf, 4'b1000);
        end
        idle(8);
        check("fair_rsp_count", 64'(rsp_cyc.size()), 64'(8));
        if (rsp_cyc.size() == 8) check("fair_back_to_back", 64'(rsp_cyc[7] - rsp_cyc[0]), 64'(7));
        check("fair_peak_inflight", 64'(peak), 64'(5));
        check("fair_inflight_drained", 64'(inflight), 64'(0));

        // Single op on requester 2: 1.0 * 2.0, latency LAT+2.
        set_op(2, 32'h0000_8000, 32'h0001_0000, 32'h0001_0000, 1'b0);
        step(4'b0100, 4'b0100);
        idle(7);
        check("single_latency", 64'(last_rsp_cyc - issue_cyc), 64'(5));

        // Sign: -1.0 * 3.0 on requester 3 (pointer now 3).
        set_op(3, 32'h8000_8000, 32'h0001_8000, 32'h8001_8000, 1'b0);
        step(4'b1000, 4'b1000);
        // Overflow, then negative zero.
        set_op(0, 32'h4000_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        step(4'b0001, 4'b0001);
        set_op(1, 32'h8000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0);
        step(4'b0010, 4'b0010);
        idle(7);
        check("hold_rsp_data", 64'(rsp_data), 64'(32'h8000_0000));
        check("hold_rsp_ovr", 64'(rsp_ovr), 64'(0));

        // Skip with pointer at 2: 5.0*2.0 on 1, (-2.0)*(-2.0) on 3.
        set_op(1, 32'h0002_8000, 32'h0001_0000, 32'h0005_0000, 1'b0);
        set_op(3, 32'h8001_0000, 32'h8001_0000, 32'h0002_0000, 1'b0);
        step(4'b1010, 4'b1000);
        step(4'b1010, 4'b0010);
        step(4'b1010, 4'b1000);
        step(4'b1010, 4'b0010);
        idle(7);
        check("skip_inflight_drained", 64'(inflight), 64'(0));

        // Reset mid-flight: pointer at 2, issue three, then reset.
        set_op(0, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 1'b0);
        step(4'hf, 4'b0100);
        step(4'hf, 4'b1000);
        step(4'hf, 4'b0001);
        rst       = 1'b1;
        req_valid = 4'hf;
        @(negedge clk);
        check("ready_in_midreset", 64'(req_ready), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        seen0 = rsp_seen;
        idle(8);
        check("no_rsp_after_reset", 64'(rsp_seen), 64'(seen0));
        check("inflight_after_reset", 64'(inflight), 64'(0));
        step(4'hf, 4'b0001);
        idle(7);

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
